seg7_scan_decoder: RTL

//  Receive-side counterpart of the multiplexed seven-segment driver. It samples the

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_anode_qual.sv | 25 ++
 rtl/seg7_scan_decoder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table, decoder FSM states and glyph lookup.
// The forward encoder indexes the same glyph table, so both directions always agree.
package seg7_pkg;

  // Active-low cathode patterns {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } seg7_dec_state_t;

  // Returns {hit, nibble}; an unknown pattern gives hit=0 and nibble 0
  function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_GLYPH[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_anode_qual.sv
// Anode qualifier: flags an anode word with exactly one active-low bit
// and encodes the position of that bit as the digit index.
module seg7_anode_qual #(
  parameter int N_DIGITS = 8,
  parameter int IDX_W    = 3
) (
  input  logic [N_DIGITS-1:0] an,
  output logic                valid,
  output logic [IDX_W-1:0]    idx
);

  always_comb begin
    int zeros;
    zeros = 0;
    idx   = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!an[k]) begin
        zeros = zeros + 1;
        idx   = IDX_W'(k);
      end
    end
    valid = (zeros == 1);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed seven-segment display, decodes each digit back to hex
// and reports the assembled word once enough identical clean frames have been seen.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_i,
  input  logic                  dp_i,
  input  logic [N_DIGITS-1:0]   an_i,
  output logic [4*N_DIGITS-1:0] value_o,
  output logic [N_DIGITS-1:0]   dp_o,
  output logic                  valid_o,
  output logic                  frame_err_o
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STB_W = $clog2(STABLE_FRAMES + 1);

  logic [6:0]          seg_s1, seg_s2;
  logic                dp_s1, dp_s2;
  logic [N_DIGITS-1:0] an_s1, an_s2;

  logic                an_valid;
  logic [IDX_W-1:0]    an_idx;

  seg7_dec_state_t     state, state_nx;
  logic [IDX_W-1:0]    cur_idx, idx_nx;
  logic [CNT_W-1:0]    settle_cnt, cnt_nx;
  logic                sample;

  logic [N_DIGITS-1:0][3:0] frame_q, frame_nx;
  logic [N_DIGITS-1:0]      dpbuf_q, dpbuf_nx;
  logic [N_DIGITS-1:0]      mask, mask_nx;
  logic                     bad, bad_nx;
  logic [4:0]               dec;
  logic                     complete;

  logic [N_DIGITS-1:0][3:0] prev_frame;
  logic [N_DIGITS-1:0]      prev_dp;
  logic                     have_prev, seen_valid, same_prev, load;
  logic [STB_W-1:0]         stable_cnt, stable_nx;

  seg7_anode_qual #(.N_DIGITS(N_DIGITS), .IDX_W(IDX_W)) u_qual (
    .an   (an_s2),
    .valid(an_valid),
    .idx  (an_idx)
  );

  // Dwell tracking: any change of anode restarts the settle count
  always_comb begin
    state_nx = state;
    idx_nx   = cur_idx;
    cnt_nx   = settle_cnt;
    sample   = 1'b0;
    if (!an_valid) begin
      state_nx = IDLE;
    end else if (state == IDLE || an_idx != cur_idx) begin
      state_nx = SETTLE;
      idx_nx   = an_idx;
      cnt_nx   = CNT_W'(1);
    end else if (state == SETTLE) begin
      cnt_nx = settle_cnt + CNT_W'(1);
    end
    if (state_nx == SETTLE && cnt_nx == CNT_W'(SETTLE_CYCLES)) begin
      sample   = 1'b1;
      state_nx = CAPTURED;
    end
  end

  // Re-sampling an already captured digit starts a fresh frame
  always_comb begin
    dec      = seg7_decode(seg_s2);
    frame_nx = frame_q;
    dpbuf_nx = dpbuf_q;
    mask_nx  = mask;
    bad_nx   = bad;
    if (sample) begin
      if (mask[idx_nx]) begin
        mask_nx = '0;
        bad_nx  = 1'b0;
      end
      mask_nx[idx_nx]  = 1'b1;
      bad_nx           = bad_nx | ~dec[4];
      frame_nx[idx_nx] = dec[3:0];
      dpbuf_nx[idx_nx] = ~dp_s2;
    end
    complete = sample && (&mask_nx);
  end

  always_comb begin
    same_prev = have_prev && (frame_nx == prev_frame) && (dpbuf_nx == prev_dp);
    stable_nx = stable_cnt;
    if (same_prev) begin
      if (stable_cnt != STB_W'(STABLE_FRAMES)) stable_nx = stable_cnt + STB_W'(1);
    end else begin
      stable_nx = STB_W'(1);
    end
    load = complete && !bad_nx && (stable_nx == STB_W'(STABLE_FRAMES)) &&
           (({frame_nx, dpbuf_nx} != {value_o, dp_o}) || !seen_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1      <= '0;
      seg_s2      <= '0;
      dp_s1       <= 1'b0;
      dp_s2       <= 1'b0;
      an_s1       <= '0;
      an_s2       <= '0;
      state       <= IDLE;
      cur_idx     <= '0;
      settle_cnt  <= '0;
      frame_q     <= '0;
      dpbuf_q     <= '0;
      mask        <= '0;
      bad         <= 1'b0;
      prev_frame  <= '0;
      prev_dp     <= '0;
      have_prev   <= 1'b0;
      seen_valid  <= 1'b0;
      stable_cnt  <= '0;
      value_o     <= '0;
      dp_o        <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      seg_s1      <= seg_i;
      seg_s2      <= seg_s1;
      dp_s1       <= dp_i;
      dp_s2       <= dp_s1;
      an_s1       <= an_i;
      an_s2       <= an_s1;
      state       <= state_nx;
      cur_idx     <= idx_nx;
      settle_cnt  <= cnt_nx;
      frame_q     <= frame_nx;
      dpbuf_q     <= dpbuf_nx;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      if (complete) begin
        mask <= '0;
        bad  <= 1'b0;
        if (bad_nx) begin
          frame_err_o <= 1'b1;
          stable_cnt  <= '0;
        end else begin
          stable_cnt <= stable_nx;
          if (!same_prev) begin
            prev_frame <= frame_nx;
            prev_dp    <= dpbuf_nx;
            have_prev  <= 1'b1;
          end
        end
      end else begin
        mask <= mask_nx;
        bad  <= bad_nx;
      end
      if (load) begin
        value_o    <= frame_nx;
        dp_o       <= dpbuf_nx;
        valid_o    <= 1'b1;
        seen_valid <= 1'b1;
      end
    end
  end

endmodule
